// File: rtl/pkt_send_module_pkg.sv
// Shared configuration for the switch packet generators: default sizing, header
// field placement and the generator FSM encoding.
package pkt_send_module_pkg;

   localparam int PORT_NUB_TOTAL_DEF  = 16;
   localparam int DATA_WIDTH_DEF      = 32;
   localparam int DATA_LENGTH_MAX_DEF = 128;
   localparam int PRIORITY_DEF        = 8;

   localparam int SEQ_WIDTH = 16;

   localparam int WIDTH_SEL_DEF      = $clog2(PORT_NUB_TOTAL_DEF);
   localparam int WIDTH_PRIORITY_DEF = $clog2(PRIORITY_DEF);
   localparam int WIDTH_LENGTH_DEF   = $clog2(DATA_LENGTH_MAX_DEF);
   localparam int WIDTH_HAND_DEF     = SEQ_WIDTH + WIDTH_LENGTH_DEF
                                     + WIDTH_PRIORITY_DEF + WIDTH_SEL_DEF;

   // Header word, LSB upward: dest, priority, length, seq, zero pad.
   localparam int DEST_LSB = 0;

   function automatic int pri_lsb(input int wsel);
      return DEST_LSB + wsel;
   endfunction

   function automatic int len_lsb(input int wsel, input int wpri);
      return pri_lsb(wsel) + wpri;
   endfunction

   function automatic int seq_lsb(input int wsel, input int wpri, input int wlen);
      return len_lsb(wsel, wpri) + wlen;
   endfunction

   localparam int PRI_LSB_DEF = pri_lsb(WIDTH_SEL_DEF);
   localparam int LEN_LSB_DEF = len_lsb(WIDTH_SEL_DEF, WIDTH_PRIORITY_DEF);
   localparam int SEQ_LSB_DEF = seq_lsb(WIDTH_SEL_DEF, WIDTH_PRIORITY_DEF, WIDTH_LENGTH_DEF);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SOP  = 3'd1,
      ST_HEAD = 3'd2,
      ST_DATA = 3'd3,
      ST_EOP  = 3'd4
   } state_t;

endpackage

// File: rtl/pkt_send_module.sv
// One-packet-per-start generator for a single switch ingress port: SOP strobe,
// header beat, L payload beats, then EOP/done. Header width must fit DATA_WIDTH.
module pkt_send_module
   import pkt_send_module_pkg::*;
#(
   parameter int tx_port         = 0,
   parameter int PORT_NUB_TOTAL  = PORT_NUB_TOTAL_DEF,
   parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
   parameter int DATA_LENGTH_MAX = DATA_LENGTH_MAX_DEF,
   parameter int PRIORITY        = PRIORITY_DEF,
   localparam int WIDTH_SEL      = $clog2(PORT_NUB_TOTAL),
   localparam int WIDTH_PRIORITY = $clog2(PRIORITY),
   localparam int WIDTH_LENGTH   = $clog2(DATA_LENGTH_MAX)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [WIDTH_SEL-1:0]      dest,
   input  logic [WIDTH_PRIORITY-1:0] prio,
   input  logic [WIDTH_LENGTH-1:0]   length,
   output logic                      ready,
   output logic                      done,
   output logic                      wr_sop,
   output logic                      wr_eop,
   output logic                      wr_vld,
   output logic [DATA_WIDTH-1:0]     wr_data
);

   localparam int PRI_LSB = pri_lsb(WIDTH_SEL);
   localparam int LEN_LSB = len_lsb(WIDTH_SEL, WIDTH_PRIORITY);
   localparam int SEQ_LSB = seq_lsb(WIDTH_SEL, WIDTH_PRIORITY, WIDTH_LENGTH);

   localparam logic [WIDTH_SEL-1:0] TX_ID = WIDTH_SEL'(tx_port);

   state_t                    state;
   state_t                    state_nxt;

   logic [WIDTH_SEL-1:0]      dest_q;
   logic [WIDTH_PRIORITY-1:0] prio_q;
   logic [WIDTH_LENGTH-1:0]   len_q;
   logic [WIDTH_LENGTH-1:0]   cnt;
   logic [SEQ_WIDTH-1:0]      seq;

   logic                      accept;
   logic                      sop_nxt;
   logic                      vld_nxt;
   logic                      eop_nxt;
   logic [DATA_WIDTH-1:0]     data_nxt;
   logic [DATA_WIDTH-1:0]     header;
   logic [DATA_WIDTH-1:0]     payload;

   // ready is only ever high while the FSM sits in IDLE
   assign accept = start && ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      header                                 = '0;
      header[DEST_LSB +: WIDTH_SEL]          = dest_q;
      header[PRI_LSB  +: WIDTH_PRIORITY]     = prio_q;
      header[LEN_LSB  +: WIDTH_LENGTH]       = len_q;
      header[SEQ_LSB  +: SEQ_WIDTH]          = seq;

      payload                                = '0;
      payload[DATA_WIDTH-1 -: WIDTH_SEL]     = TX_ID;
      payload[WIDTH_LENGTH-1:0]              = cnt;
   end

   // Outputs are decoded from the current state and registered, so every
   // wire-level event lags its state by one clock.
   always_comb begin
      state_nxt = state;
      sop_nxt   = 1'b0;
      vld_nxt   = 1'b0;
      eop_nxt   = 1'b0;
      data_nxt  = '0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = ST_SOP;
            end
         end
         ST_SOP: begin
            sop_nxt   = 1'b1;
            state_nxt = ST_HEAD;
         end
         ST_HEAD: begin
            vld_nxt   = 1'b1;
            data_nxt  = header;
            state_nxt = (len_q == '0) ? ST_EOP : ST_DATA;
         end
         ST_DATA: begin
            vld_nxt  = 1'b1;
            data_nxt = payload;
            if (cnt == (len_q - WIDTH_LENGTH'(1))) begin
               state_nxt = ST_EOP;
            end
         end
         ST_EOP: begin
            eop_nxt   = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ready   <= 1'b0;
         done    <= 1'b0;
         wr_sop  <= 1'b0;
         wr_eop  <= 1'b0;
         wr_vld  <= 1'b0;
         wr_data <= '0;
         cnt     <= '0;
         seq     <= '0;
      end else begin
         ready   <= (state == ST_IDLE) && !accept;
         done    <= eop_nxt;
         wr_sop  <= sop_nxt;
         wr_eop  <= eop_nxt;
         wr_vld  <= vld_nxt;
         wr_data <= data_nxt;
         cnt     <= (state == ST_DATA) ? cnt + WIDTH_LENGTH'(1) : '0;
         if (state == ST_EOP) begin
            seq <= seq + SEQ_WIDTH'(1);
         end
      end
   end

   // Request fields are held for the whole packet; they need no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         dest_q <= dest;
         prio_q <= prio;
         len_q  <= length;
      end
   end

endmodule

// File: tb/tb_pkt_send_module.sv
// Cycle-schedule reference bench for pkt_send_module (tx_port=3, default sizing).
module tb_pkt_send_module;

   localparam int TX   = 3;
   localparam int MAXC = 8192;
   // packed observation: {ready, done, sop, eop, vld, data[31:0]}
   localparam logic [36:0] IDLE_V = {1'b1, 36'd0};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  dest = '0;
   logic [2:0]  prio = '0;
   logic [6:0]  length = '0;
   logic        ready, done, wr_sop, wr_eop, wr_vld;
   logic [31:0] wr_data;
   logic [36:0] obs;

   logic [36:0] exp_v [MAXC];
   int          edge_n = 0;
   int          vectors = 0;
   int          miscompares = 0;
   int          seq_model = 0;

   assign obs = {ready, done, wr_sop, wr_eop, wr_vld, wr_data};

   pkt_send_module #(.tx_port(TX)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dest(dest), .prio(prio),
      .length(length), .ready(ready), .done(done), .wr_sop(wr_sop),
      .wr_eop(wr_eop), .wr_vld(wr_vld), .wr_data(wr_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   function automatic logic [31:0] hdr_word(input int s, input int d, input int p, input int l);
      return 32'(((s & 32'hFFFF) << 14) | (l << 7) | (p << 4) | d);
   endfunction

   function automatic logic [31:0] pay_word(input int k);
      return 32'((TX << 28) | k);
   endfunction

   // Expected outputs after edges t .. t+3+l for a packet accepted at edge t.
   task automatic plan_packet(input int t, input int d, input int p, input int l);
      exp_v[t]     = '0;
      exp_v[t + 1] = {3'b001, 2'b00, 32'd0};
      exp_v[t + 2] = {4'b0000, 1'b1, hdr_word(seq_model, d, p, l)};
      for (int k = 0; k < l; k++) exp_v[t + 3 + k] = {4'b0000, 1'b1, pay_word(k)};
      exp_v[t + 3 + l] = {2'b01, 1'b0, 1'b1, 1'b0, 32'd0};
      seq_model = (seq_model + 1) % 65536;
   endtask

   task automatic issue(input int d, input int p, input int l);
      start  = 1'b1;
      dest   = 4'(d);
      prio   = 3'(p);
      length = 7'(l);
      if (rst_n && exp_v[edge_n][36]) plan_packet(edge_n + 1, d, p, l);
   endtask

   task automatic quiet();
      start  = 1'b0;
      dest   = 4'($urandom);
      prio   = 3'($urandom);
      length = 7'($urandom);
   endtask

   task automatic reset_on(input int n);
      rst_n = 1'b0;
      for (int c = 1; c <= n; c++) exp_v[edge_n + c] = '0;
      for (int c = n + 1; c <= n + 300; c++) exp_v[edge_n + c] = IDLE_V;
      seq_model = 0;
   endtask

   task automatic test_reset();
      for (int c = 0; c <= 6; c++) exp_v[c] = '0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         vectors++;
         if (obs !== exp_v[edge_n]) begin
            miscompares++;
            $display("FAIL reset edge=%0d got=%h want=%h", edge_n, obs, exp_v[edge_n]);
         end
         if (i == 5) rst_n = 1'b1;
         quiet();
      end
   endtask

   task automatic test_single();
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         vectors++;
         if (obs !== exp_v[edge_n]) begin
            miscompares++;
            $display("FAIL single edge=%0d got=%h want=%h", edge_n, obs, exp_v[edge_n]);
         end
         if (i == 0) issue(5, 1, 16);
         else quiet();
      end
   endtask

   task automatic test_back_to_back();
      int lens[2] = '{16, 65};
      int sent = 0;
      int vld_beats = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         vectors++;
         if (obs !== exp_v[edge_n]) begin
            miscompares++;
            $display("FAIL back_to_back edge=%0d got=%h want=%h", edge_n, obs, exp_v[edge_n]);
         end
         if (wr_vld === 1'b1) vld_beats++;
         if (sent < 2 && exp_v[edge_n][36]) begin
            issue($urandom_range(0, 15), $urandom_range(0, 7), lens[sent]);
            sent++;
         end else begin
            quiet();
         end
      end
      vectors++;
      if (vld_beats != 83) begin
         miscompares++;
         $display("FAIL b2b_beats got=%0d want=83", vld_beats);
      end
   endtask

   task automatic test_busy_start();
      int sops = 0;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         vectors++;
         if (obs !== exp_v[edge_n]) begin
            miscompares++;
            $display("FAIL busy edge=%0d got=%h want=%h", edge_n, obs, exp_v[edge_n]);
         end
         if (wr_sop === 1'b1) sops++;
         if (i == 0 || (i >= 3 && i <= 6) || i == 10)
            issue($urandom_range(0, 15), $urandom_range(0, 7), (i == 0) ? 8 : $urandom_range(1, 100));
         else quiet();
      end
      vectors++;
      if (sops != 1) begin
         miscompares++;
         $display("FAIL busy_sop_count got=%0d want=1", sops);
      end
   endtask

   task automatic test_len_zero();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         vectors++;
         if (obs !== exp_v[edge_n]) begin
            miscompares++;
            $display("FAIL len_zero edge=%0d got=%h want=%h", edge_n, obs, exp_v[edge_n]);
         end
         if (i == 0) issue($urandom_range(0, 15), $urandom_range(0, 7), 0);
         else quiet();
      end
   endtask

   task automatic test_reset_mid();
      int t0 = -100;
      int t1 = -100;
      int rel = -100;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         vectors++;
         if (obs !== exp_v[edge_n]) begin
            miscompares++;
            $display("FAIL reset_mid edge=%0d got=%h want=%h", edge_n, obs, exp_v[edge_n]);
         end
         if (edge_n == t1 + 2) begin
            vectors++;
            if (wr_data[29:14] !== 16'd0) begin
               miscompares++;
               $display("FAIL reset_mid_seq got=%0d want=0", wr_data[29:14]);
            end
         end
         if (i == 0) begin
            issue($urandom_range(0, 15), $urandom_range(0, 7), 20);
            t0 = edge_n + 1;
         end else if (edge_n == t0 + 12) begin
            start = 1'b0;
            reset_on(3);
            rel = edge_n + 3;
         end else if (edge_n == rel) begin
            rst_n = 1'b1;
            quiet();
         end else if (edge_n == rel + 3) begin
            issue($urandom_range(0, 15), $urandom_range(0, 7), 5);
            t1 = edge_n + 1;
         end else begin
            quiet();
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         vectors++;
         if (obs !== exp_v[edge_n]) begin
            miscompares++;
            $display("FAIL random edge=%0d got=%h want=%h", edge_n, obs, exp_v[edge_n]);
         end
         if (i < 560 && $urandom_range(0, 3) == 0)
            issue($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 40));
         else quiet();
      end
   endtask

   initial begin
      for (int c = 0; c < MAXC; c++) exp_v[c] = IDLE_V;
      test_reset();
      test_single();
      test_back_to_back();
      test_busy_start();
      test_len_zero();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
